commu_rx_frm: RTL and testbench
===============================

# commu_rx_frm

Frame receiver at the far end of the head/push/tail link driven by the communication main FSM. It parses the incoming byte stream (head, length, payload, checksum, tail), forwards payload bytes cut-through, and reports each frame as good or bad. On a bad frame it raises the 8-bit retry command consumed by the sender's main FSM, where retry = bit0 & bit1.

## Interface
Parameters:
- HEAD0, 8'hEB, first sync byte
- HEAD1, 8'h90, second sync byte
- TAIL, 8'h0D, frame terminator
- MAX_LEN, 64, largest legal payload length (1..255)
- TIMEOUT, 16'd1000, inter-byte timeout in clk_sys cycles

Ports:
- clk_sys  in  1  system clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rx_vld  in  1  rx_data valid this cycle (single-cycle strobe per byte)
- rx_data  in  8  received byte
- pay_vld  out  1  payload byte valid
- pay_data  out  8  payload byte
- pay_last  out  1  qualifies last payload byte of frame
- frm_ok  out  1  one-cycle pulse, frame accepted
- frm_err  out  1  one-cycle pulse, frame rejected
- err_code  out  2  cause, valid with frm_err, held until next frm_err: 0 bad length, 1 checksum, 2 tail, 3 timeout
- cmd_retry  out  8  8'h03 for one cycle with frm_err, else 8'h00
- frm_cnt  out  16  count of good frames, wraps 16'hFFFF -> 0
- busy  out  1  high whenever state != S_IDLE

## Operation
- Frame format: HEAD0 HEAD1 LEN P[0..LEN-1] CHK TAIL. CHK = (LEN + sum P) mod 256, 8-bit.
- FSM states: S_IDLE, S_HEAD1, S_LEN, S_PAY, S_CHK, S_TAIL. Transitions happen only on rx_vld, except timeout.
- S_IDLE: byte==HEAD0 -> S_HEAD1; else stay.
- S_HEAD1: byte==HEAD1 -> S_LEN; byte==HEAD0 -> stay in S_HEAD1; else -> S_IDLE. No error is reported for sync loss.
- S_LEN: byte==0 or byte>MAX_LEN -> error 0, S_IDLE. Else latch len, load checksum accumulator with byte, clear byte counter, -> S_PAY.
- S_PAY: forward byte, add to accumulator, increment counter; on byte index len-1 -> S_CHK.
- S_CHK: byte != accumulator -> error 1, S_IDLE; else -> S_TAIL.
- S_TAIL: byte==TAIL -> frm_ok, frm_cnt+1, S_IDLE; else error 2, S_IDLE.
- Timeout: counter cleared on every rx_vld and in S_IDLE. When TIMEOUT consecutive cycles pass without rx_vld in any non-idle state -> error 3, S_IDLE.
- Payload is cut-through. Downstream discards any partially received frame when frm_err is seen after pay_last, or when frm_err arrives mid-payload.
- Error and good-frame paths never coincide; every frame that leaves S_LEN ends in exactly one frm_ok or frm_err.

## Timing
- Reset values: pay_vld, pay_last, frm_ok, frm_err = 0; pay_data, err_code = 0; cmd_retry = 8'h00; frm_cnt = 0; busy = 0; state = S_IDLE; accumulator, counters = 0.
- All outputs are registered. pay_vld/pay_data/pay_last appear 1 cycle after the rx_vld cycle of the payload byte.
- frm_ok, frm_err and cmd_retry pulse exactly 1 cycle, in the cycle after the deciding byte. For timeout, the pulse comes in the cycle after the TIMEOUT-th idle cycle.
- frm_cnt updates in the same cycle frm_ok is high.
- No dead cycles: the FSM is in S_IDLE in the cycle after the deciding byte, so a HEAD0 arriving in that cycle starts a new frame.
- Back-to-back rx_vld on every cycle is supported at full rate.
- Asynchronous reset mid-frame aborts without pulsing frm_err; all outputs return to reset values immediately.

## Test plan
- Good frame EB 90 02 11 22 35 0D, one byte per cycle -> pay_vld with 11, then 22 with pay_last=1; frm_ok 1 cycle after 0D; frm_cnt 0->1; cmd_retry stays 00.
- Checksum error EB 90 02 11 22 36 0D -> frm_err 1 cycle after 36, err_code=1, cmd_retry=03 for exactly 1 cycle, frm_cnt unchanged.
- Length errors: LEN=00, then LEN=41 with MAX_LEN=64 -> frm_err with err_code=0 after each LEN byte; no pay_vld.
- Sync recovery EB EB 90 01 AA AB 0D -> one frm_ok with payload AA; a bad tail 0C instead gives err_code=2.
- Timeout: stop after EB 90 03 11 for TIMEOUT cycles -> frm_err with err_code=3 exactly TIMEOUT+1 cycles after 11's rx_vld; busy drops the same cycle.
- Back-to-back good frames with no gap, preloaded with frm_cnt=FFFF -> two frm_ok pulses; frm_cnt wraps FFFF->0000->0001.

Source files
------------

// File: rtl/commu_rx_frm_if.sv
`default_nettype none
// ============================================================================
// Module   : commu_rx_frm_if
// Purpose  : Bundles the receive byte stream and the frame-report outputs of
//            commu_rx_frm into one interface.
//   master : byte source / downstream consumer side
//            (drives rx_vld, rx_data; observes every result signal)
//   slave  : the frame receiver itself
//            (takes rx_vld, rx_data; drives every result signal)
// Signals  : rx_vld/rx_data          one strobe per received byte
//            pay_vld/pay_data/pay_last  cut-through payload stream
//            frm_ok/frm_err/err_code    per-frame verdict
//            cmd_retry                  retry command to the sender (8'h03)
//            frm_cnt                    good-frame counter
//            busy                       receiver is inside a frame
// Revision : 1.0  initial release
// ============================================================================
interface commu_rx_frm_if;
  logic        rx_vld;
  logic [7:0]  rx_data;
  logic        pay_vld;
  logic [7:0]  pay_data;
  logic        pay_last;
  logic        frm_ok;
  logic        frm_err;
  logic [1:0]  err_code;
  logic [7:0]  cmd_retry;
  logic [15:0] frm_cnt;
  logic        busy;

  modport master (
    output rx_vld, rx_data,
    input  pay_vld, pay_data, pay_last, frm_ok, frm_err, err_code,
           cmd_retry, frm_cnt, busy
  );

  modport slave (
    input  rx_vld, rx_data,
    output pay_vld, pay_data, pay_last, frm_ok, frm_err, err_code,
           cmd_retry, frm_cnt, busy
  );
endinterface
`default_nettype wire

// File: rtl/commu_rx_frm.sv
`default_nettype none
// ============================================================================
// Module   : commu_rx_frm
// Purpose  : Frame receiver for the head/push/tail link. Parses
//            HEAD0 HEAD1 LEN P[0..LEN-1] CHK TAIL, forwards payload bytes
//            cut-through and reports every frame as good (frm_ok) or bad
//            (frm_err + err_code + cmd_retry).
// Ports    : clk_sys  system clock, rising edge
//            rst_n    asynchronous active-low reset
//            bus      commu_rx_frm_if.slave
//                       in : rx_vld, rx_data
//                       out: pay_vld, pay_data, pay_last, frm_ok, frm_err,
//                            err_code, cmd_retry, frm_cnt, busy
// Params   : HEAD0/HEAD1  sync bytes
//            TAIL         frame terminator
//            MAX_LEN      largest legal payload length (1..255)
//            TIMEOUT      inter-byte timeout in clk_sys cycles (>= 1)
//            FRM_CNT_INIT value frm_cnt takes in reset
// Revision : 1.0  initial release
// ============================================================================
module commu_rx_frm #(
  parameter logic [7:0]  HEAD0        = 8'hEB,
  parameter logic [7:0]  HEAD1        = 8'h90,
  parameter logic [7:0]  TAIL         = 8'h0D,
  parameter int unsigned MAX_LEN      = 64,
  parameter logic [15:0] TIMEOUT      = 16'd1000,
  parameter logic [15:0] FRM_CNT_INIT = 16'h0000
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  commu_rx_frm_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD1 = 3'd1,
    S_LEN   = 3'd2,
    S_PAY   = 3'd3,
    S_CHK   = 3'd4,
    S_TAIL  = 3'd5
  } state_t;

  localparam logic [7:0]  c_max_len   = MAX_LEN[7:0];
  // The counter value seen on the TIMEOUT-th silent cycle.
  localparam logic [15:0] c_tmo_last  = TIMEOUT - 16'd1;
  // The sender's FSM decodes retry as bit0 & bit1.
  localparam logic [7:0]  c_retry     = 8'h03;
  localparam logic [1:0]  c_err_len   = 2'd0;
  localparam logic [1:0]  c_err_chk   = 2'd1;
  localparam logic [1:0]  c_err_tail  = 2'd2;
  localparam logic [1:0]  c_err_tmo   = 2'd3;

  state_t      r_state;
  logic [7:0]  r_len;
  logic [7:0]  r_acc;
  logic [7:0]  r_idx;
  logic [15:0] r_tmo;

  logic        r_pay_vld;
  logic [7:0]  r_pay_data;
  logic        r_pay_last;
  logic        r_frm_ok;
  logic        r_frm_err;
  logic [1:0]  r_err_code;
  logic [7:0]  r_cmd_retry;
  logic [15:0] r_frm_cnt;
  logic        r_busy;

  logic        w_err_fire;
  logic [1:0]  w_err_cause;

  // --------------------------------------------------------------------------
  // Rejection decode. All four causes are mutually exclusive: three need a
  // byte in a specific state, the timeout needs the absence of a byte.
  // --------------------------------------------------------------------------
  always_comb begin
    w_err_fire  = 1'b0;
    w_err_cause = c_err_len;
    if (bus.rx_vld) begin
      case (r_state)
        S_LEN: begin
          if ((bus.rx_data == 8'h00) || (bus.rx_data > c_max_len)) begin
            w_err_fire  = 1'b1;
            w_err_cause = c_err_len;
          end
        end
        S_CHK: begin
          if (bus.rx_data != r_acc) begin
            w_err_fire  = 1'b1;
            w_err_cause = c_err_chk;
          end
        end
        S_TAIL: begin
          if (bus.rx_data != TAIL) begin
            w_err_fire  = 1'b1;
            w_err_cause = c_err_tail;
          end
        end
        default: ;
      endcase
    end else if ((r_state != S_IDLE) && (r_tmo == c_tmo_last)) begin
      w_err_fire  = 1'b1;
      w_err_cause = c_err_tmo;
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM with registered outputs. Every transition back to S_IDLE takes
  // effect on the deciding edge, so a HEAD0 in the very next cycle is parsed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= 8'h00;
      r_acc       <= 8'h00;
      r_idx       <= 8'h00;
      r_tmo       <= 16'h0000;
      r_pay_vld   <= 1'b0;
      r_pay_data  <= 8'h00;
      r_pay_last  <= 1'b0;
      r_frm_ok    <= 1'b0;
      r_frm_err   <= 1'b0;
      r_err_code  <= 2'd0;
      r_cmd_retry <= 8'h00;
      r_frm_cnt   <= FRM_CNT_INIT;
      r_busy      <= 1'b0;
    end else begin
      // Pulse outputs default low; pay_data and err_code hold.
      r_pay_vld   <= 1'b0;
      r_pay_last  <= 1'b0;
      r_frm_ok    <= 1'b0;
      r_frm_err   <= 1'b0;
      r_cmd_retry <= 8'h00;

      // Silence counter only runs while inside a frame.
      if ((r_state == S_IDLE) || bus.rx_vld) begin
        r_tmo <= 16'h0000;
      end else begin
        r_tmo <= r_tmo + 16'd1;
      end

      if (w_err_fire) begin
        r_frm_err   <= 1'b1;
        r_err_code  <= w_err_cause;
        r_cmd_retry <= c_retry;
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
      end else if (bus.rx_vld) begin
        case (r_state)
          S_IDLE: begin
            if (bus.rx_data == HEAD0) begin
              r_state <= S_HEAD1;
              r_busy  <= 1'b1;
            end
          end

          S_HEAD1: begin
            // A repeated HEAD0 keeps the hunt alive; anything else drops
            // sync silently.
            if (bus.rx_data == HEAD1) begin
              r_state <= S_LEN;
            end else if (bus.rx_data != HEAD0) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end

          S_LEN: begin
            // Length already validated by the rejection decode.
            r_len   <= bus.rx_data;
            r_acc   <= bus.rx_data;
            r_idx   <= 8'h00;
            r_state <= S_PAY;
          end

          S_PAY: begin
            r_pay_vld  <= 1'b1;
            r_pay_data <= bus.rx_data;
            r_acc      <= r_acc + bus.rx_data;
            r_idx      <= r_idx + 8'd1;
            if (r_idx == (r_len - 8'd1)) begin
              r_pay_last <= 1'b1;
              r_state    <= S_CHK;
            end
          end

          S_CHK: begin
            r_state <= S_TAIL;
          end

          S_TAIL: begin
            r_frm_ok  <= 1'b1;
            r_frm_cnt <= r_frm_cnt + 16'd1;
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
          end

          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pay_vld   = r_pay_vld;
  assign bus.pay_data  = r_pay_data;
  assign bus.pay_last  = r_pay_last;
  assign bus.frm_ok    = r_frm_ok;
  assign bus.frm_err   = r_frm_err;
  assign bus.err_code  = r_err_code;
  assign bus.cmd_retry = r_cmd_retry;
  assign bus.frm_cnt   = r_frm_cnt;
  assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_commu_rx_frm.sv
`default_nettype none
// ============================================================================
// Module   : tb_commu_rx_frm
// Purpose  : Self-checking bench for commu_rx_frm. Two receivers see the same
//            byte stream; the second one starts its frame counter at 16'hFFFF
//            so the counter wrap shows up on the first good frames.
//            Expected outputs come from a byte-stream parser that schedules
//            per-edge events, checked against both receivers every cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_commu_rx_frm;

  localparam logic [15:0] TMO  = 16'd1000;
  localparam int          MAXL = 64;

  logic clk_sys = 1'b0;
  logic rst_n   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  commu_rx_frm_if if_a ();
  commu_rx_frm_if if_b ();

  commu_rx_frm #(
    .HEAD0(8'hEB), .HEAD1(8'h90), .TAIL(8'h0D), .MAX_LEN(MAXL),
    .TIMEOUT(TMO), .FRM_CNT_INIT(16'h0000)
  ) dut_a (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(if_a.slave)
  );

  commu_rx_frm #(
    .HEAD0(8'hEB), .HEAD1(8'h90), .TAIL(8'h0D), .MAX_LEN(MAXL),
    .TIMEOUT(TMO), .FRM_CNT_INIT(16'hFFFF)
  ) dut_b (
    .clk_sys(clk_sys), .rst_n(rst_n), .bus(if_b.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int edge_n = 0;
  bit chk_en = 1'b0;

  // Expected events keyed by the clock edge after which they are visible.
  logic [7:0] m_pay [int];
  bit         m_last[int];
  bit         m_ok  [int];
  logic [1:0] m_err [int];
  bit         m_busy[int];

  logic [15:0] cur_cnt_a;
  logic [15:0] cur_cnt_b;
  logic [1:0]  cur_code;
  bit          cur_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", name, edge_n, act, exp);
    end
  endtask

  // Walks a contiguous burst (byte i sampled on edge e0+i, receiver idle at
  // the start) and schedules every output event the frame rules imply.
  function automatic void predict(input logic [7:0] b[$], input int e0,
                                  output bit open, output int elast);
    int i;
    int n;
    int len;
    logic [7:0] sum;
    i     = 0;
    n     = b.size();
    open  = 1'b0;
    elast = e0 + n - 1;
    while (i < n) begin
      if (b[i] != 8'hEB) begin i++; continue; end
      m_busy[e0+i] = 1'b1;
      i++;
      while ((i < n) && (b[i] == 8'hEB)) i++;
      if (i >= n) begin open = 1'b1; return; end
      if (b[i] != 8'h90) begin m_busy[e0+i] = 1'b0; i++; continue; end
      i++;
      if (i >= n) begin open = 1'b1; return; end
      len = int'(b[i]);
      if ((len == 0) || (len > MAXL)) begin
        m_err[e0+i]  = 2'd0;
        m_busy[e0+i] = 1'b0;
        i++;
        continue;
      end
      sum = b[i];
      i++;
      for (int p = 0; p < len; p++) begin
        if (i >= n) begin open = 1'b1; return; end
        m_pay[e0+i] = b[i];
        if (p == len - 1) m_last[e0+i] = 1'b1;
        sum = sum + b[i];
        i++;
      end
      if (i >= n) begin open = 1'b1; return; end
      if (b[i] != sum) begin
        m_err[e0+i]  = 2'd1;
        m_busy[e0+i] = 1'b0;
        i++;
        continue;
      end
      i++;
      if (i >= n) begin open = 1'b1; return; end
      if (b[i] == 8'h0D) m_ok[e0+i] = 1'b1;
      else               m_err[e0+i] = 2'd2;
      m_busy[e0+i] = 1'b0;
      i++;
    end
  endfunction

  // Per-cycle comparison of both receivers against the scheduled events.
  always @(negedge clk_sys) begin : p_cmp
    bit         e_pv;
    bit         e_pl;
    bit         e_ok;
    bit         e_er;
    logic [7:0] e_pd;
    if (chk_en) begin
      e_pv = m_pay.exists(edge_n);
      e_pd = e_pv ? m_pay[edge_n] : 8'h00;
      e_pl = m_last.exists(edge_n);
      e_ok = m_ok.exists(edge_n);
      e_er = m_err.exists(edge_n);
      if (e_er) cur_code = m_err[edge_n];
      if (e_ok) begin
        cur_cnt_a = cur_cnt_a + 16'd1;
        cur_cnt_b = cur_cnt_b + 16'd1;
      end
      if (m_busy.exists(edge_n)) cur_busy = m_busy[edge_n];
      chk("a_pay_vld",   if_a.pay_vld,   e_pv);
      if (e_pv) chk("a_pay_data", if_a.pay_data, e_pd);
      chk("a_pay_last",  if_a.pay_last,  e_pl);
      chk("a_frm_ok",    if_a.frm_ok,    e_ok);
      chk("a_frm_err",   if_a.frm_err,   e_er);
      chk("a_err_code",  if_a.err_code,  cur_code);
      chk("a_cmd_retry", if_a.cmd_retry, e_er ? 8'h03 : 8'h00);
      chk("a_frm_cnt",   if_a.frm_cnt,   cur_cnt_a);
      chk("a_busy",      if_a.busy,      cur_busy);
      chk("b_pay_vld",   if_b.pay_vld,   e_pv);
      chk("b_frm_ok",    if_b.frm_ok,    e_ok);
      chk("b_frm_err",   if_b.frm_err,   e_er);
      chk("b_frm_cnt",   if_b.frm_cnt,   cur_cnt_b);
      chk("b_busy",      if_b.busy,      cur_busy);
    end
  end

  task automatic step(input bit v, input logic [7:0] d);
    if_a.rx_vld  = v;
    if_a.rx_data = d;
    if_b.rx_vld  = v;
    if_b.rx_data = d;
    @(posedge clk_sys);
    edge_n++;
    @(negedge clk_sys);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 8'h00);
  endtask

  task automatic send(input logic [7:0] b[$], output bit open, output int elast);
    predict(b, edge_n + 1, open, elast);
    foreach (b[i]) step(1'b1, b[i]);
  endtask

  task automatic model_reset();
    cur_cnt_a = 16'h0000;
    cur_cnt_b = 16'hFFFF;
    cur_code  = 2'd0;
    cur_busy  = 1'b0;
  endtask

  initial begin : p_watchdog
    #2000000;
    n_fail++;
    $display("FAIL watchdog edge=%0d got=running exp=finished", edge_n);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin : p_main
    logic [7:0] q[$];
    logic [7:0] sum;
    bit         open;
    int         elast;
    int         e0;

    if_a.rx_vld = 1'b0; if_a.rx_data = 8'h00;
    if_b.rx_vld = 1'b0; if_b.rx_data = 8'h00;
    model_reset();
    @(negedge clk_sys);
    idle(3);
    chk("rst_pay_vld",   if_a.pay_vld,   0);
    chk("rst_frm_err",   if_a.frm_err,   0);
    chk("rst_cmd_retry", if_a.cmd_retry, 8'h00);
    chk("rst_frm_cnt_a", if_a.frm_cnt,   16'h0000);
    chk("rst_frm_cnt_b", if_b.frm_cnt,   16'hFFFF);
    chk("rst_busy",      if_a.busy,      0);
    chk("rst_err_code",  if_a.err_code,  0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    idle(2);

    // Back-to-back good frames; counter B wraps FFFF -> 0000 -> 0001.
    q = {8'hEB, 8'h90, 8'h02, 8'h11, 8'h22, 8'h35, 8'h0D,
         8'hEB, 8'h90, 8'h01, 8'hAA, 8'hAB, 8'h0D};
    e0 = edge_n + 1;
    predict(q, e0, open, elast);
    chk("pin_pay0", m_pay.exists(e0+3) ? m_pay[e0+3] : 8'h00, 8'h11);
    chk("pin_last", m_last.exists(e0+4), 1);
    chk("pin_ok2",  m_ok.exists(e0+12), 1);
    foreach (q[i]) begin
      step(1'b1, q[i]);
      if (i == 3) chk("lit_pay_11", {if_a.pay_vld, if_a.pay_last, if_a.pay_data}, {2'b10, 8'h11});
      if (i == 4) chk("lit_pay_22", {if_a.pay_vld, if_a.pay_last, if_a.pay_data}, {2'b11, 8'h22});
      if (i == 6) begin
        chk("lit_ok1",        if_a.frm_ok,    1);
        chk("lit_cnt_a1",     if_a.frm_cnt,   16'h0001);
        chk("lit_cnt_b_wrap", if_b.frm_cnt,   16'h0000);
        chk("lit_retry_ok",   if_a.cmd_retry, 8'h00);
      end
      if (i == 7) chk("lit_no_dead", if_a.busy, 1);
      if (i == 12) chk("lit_cnt_b1", if_b.frm_cnt, 16'h0001);
    end
    idle(3);

    // Checksum error.
    q = {8'hEB, 8'h90, 8'h02, 8'h11, 8'h22, 8'h36, 8'h0D};
    e0 = edge_n + 1;
    predict(q, e0, open, elast);
    chk("pin_err_chk", m_err.exists(e0+5) ? 32'(m_err[e0+5]) : 32'hFF, 1);
    foreach (q[i]) begin
      step(1'b1, q[i]);
      if (i == 5) begin
        chk("lit_chk_err",   {if_a.frm_err, if_a.err_code}, {1'b1, 2'd1});
        chk("lit_chk_retry", if_a.cmd_retry, 8'h03);
        chk("lit_chk_cnt",   if_a.frm_cnt,   16'h0002);
      end
      if (i == 6) chk("lit_chk_retry_end", if_a.cmd_retry, 8'h00);
    end
    idle(3);

    // Length errors: zero and MAX_LEN+1.
    q = {8'hEB, 8'h90, 8'h00};
    send(q, open, elast);
    chk("lit_len0", {if_a.frm_err, if_a.err_code}, {1'b1, 2'd0});
    idle(2);
    q = {8'hEB, 8'h90, 8'h41};
    send(q, open, elast);
    chk("lit_len41", {if_a.frm_err, if_a.err_code}, {1'b1, 2'd0});
    idle(2);

    // Longest legal frame (LEN = MAX_LEN).
    q = {8'hEB, 8'h90, 8'd64};
    sum = 8'd64;
    for (int p = 0; p < 64; p++) begin
      q.push_back(8'(p * 3 + 1));
      sum = sum + 8'(p * 3 + 1);
    end
    q.push_back(sum);
    q.push_back(8'h0D);
    send(q, open, elast);
    chk("lit_maxlen_ok", if_a.frm_ok, 1);
    idle(2);

    // Sync recovery through a repeated HEAD0, then a bad tail.
    q = {8'hEB, 8'hEB, 8'h90, 8'h01, 8'hAA, 8'hAB, 8'h0D};
    send(q, open, elast);
    chk("lit_sync_ok", if_a.frm_ok, 1);
    idle(1);
    q = {8'hEB, 8'h90, 8'h01, 8'hAA, 8'hAB, 8'h0C};
    send(q, open, elast);
    chk("lit_tail_err", {if_a.frm_err, if_a.err_code}, {1'b1, 2'd2});
    idle(2);

    // Silent sync loss, then an oversized length.
    q = {8'hEB, 8'h55, 8'h90, 8'hEB, 8'h90, 8'hFF};
    send(q, open, elast);
    chk("lit_lenff", {if_a.frm_err, if_a.err_code}, {1'b1, 2'd0});
    idle(2);

    // Timeout mid-payload.
    q = {8'hEB, 8'h90, 8'h03, 8'h11};
    send(q, open, elast);
    chk("pin_open", open, 1);
    m_err[elast + int'(TMO)]  = 2'd3;
    m_busy[elast + int'(TMO)] = 1'b0;
    idle(int'(TMO) - 1);
    chk("lit_tmo_early", {if_a.frm_err, if_a.busy}, 2'b01);
    idle(1);
    chk("lit_tmo_err",   {if_a.frm_err, if_a.busy, if_a.err_code}, {2'b10, 2'd3});
    chk("lit_tmo_retry", if_a.cmd_retry, 8'h03);
    idle(2);
    q = {8'hEB, 8'h90, 8'h01, 8'hAA, 8'hAB, 8'h0D};
    send(q, open, elast);
    idle(2);

    // Asynchronous reset in the middle of a payload.
    q = {8'hEB, 8'h90, 8'h03, 8'h11};
    send(q, open, elast);
    chk_en = 1'b0;
    if_a.rx_vld = 1'b0;
    if_b.rx_vld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pay_vld", if_a.pay_vld, 0);
    chk("arst_busy",    if_a.busy,    0);
    chk("arst_cnt_a",   if_a.frm_cnt, 16'h0000);
    chk("arst_cnt_b",   if_b.frm_cnt, 16'hFFFF);
    @(negedge clk_sys);
    idle(2);
    chk("arst_no_err", if_a.frm_err, 0);
    rst_n = 1'b1;
    model_reset();
    chk_en = 1'b1;
    idle(1);
    q = {8'hEB, 8'h90, 8'h02, 8'h11, 8'h22, 8'h35, 8'h0D};
    send(q, open, elast);
    chk("lit_after_rst", {if_a.frm_ok, if_a.frm_cnt}, {1'b1, 16'h0001});
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
